// File: rtl/md_pkg.sv
// md_pkg: op encodings shared by the multiply/divide unit and its users.
package md_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational product, quotient and remainder for the latched operands.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic sgn, sa, sb;
  logic [WIDTH-1:0] ua, ub, q, r;
  logic [2*WIDTH-1:0] prod;
  // Signed division works on magnitudes, then restores signs: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    sgn = op == OP_DIV;
    sa = sgn & a[WIDTH-1];
    sb = sgn & b[WIDTH-1];
    ua = sa ? -a : a;
    ub = sb ? -b : b;
    q = ub == '0 ? '0 : ua / ub;
    r = ub == '0 ? '0 : ua % ub;
    prod = op == OP_MULT ? {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}
                         : {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    {hi, lo} = (op == OP_MULT || op == OP_MULTU) ? prod
             : b == '0 ? {a, {WIDTH{1'b1}}}
             : (sgn && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) ? {{WIDTH{1'b0}}, a}
             : {sa ? -r : r, (sa ^ sb) ? -q : q};
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit with fixed-latency busy window and MFHI/MFLO read port.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);
  localparam int CMAX = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, r_hi, r_lo;
  logic accept, is_mul, is_div;
  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .hi(r_hi),
    .lo(r_lo)
  );
  assign busy = cnt != '0;
  assign accept = start & ~flush & ~busy;
  assign is_mul = op == OP_MULT || op == OP_MULTU;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign rdata = op == OP_MFHI ? hi : lo;
  // The result is committed on the edge that takes the counter from 1 to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi <= '0;
      lo <= '0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= r_hi;
        lo <= r_lo;
      end
    end else if (accept) begin
      op_q <= op;
      a_q <= a;
      b_q <= b;
      cnt <= is_mul ? CW'(MUL_CYCLES) : is_div ? CW'(DIV_CYCLES) : '0;
      if (op == OP_MTHI) hi <= a;
      if (op == OP_MTLO) lo <= a;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;
  logic clk = 0, reset = 0, start = 0, flush = 0;
  logic [3:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy;
  logic [31:0] hi, lo, rdata;
  int total = 0, bad = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic m_busy = 0;
  logic [63:0] m_res = 0;
  int cyc = 0, done_edge = 0;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] golden(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = 0;
    case (o)
      4'd1: p = sx * sy;
      4'd2: p = {32'b0, x} * {32'b0, y};
      4'd3: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      4'd4: p = y == 0 ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: p = 0;
    endcase
    return p;
  endfunction

  // Reference model: results appear a fixed number of edges after acceptance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 0;
      m_lo <= 0;
      m_busy <= 0;
      cyc <= 0;
      done_edge <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (cyc + 1 == done_edge) begin
          {m_hi, m_lo} <= m_res;
          m_busy <= 0;
        end
      end else if (start && !flush) begin
        if (op == 4'd1 || op == 4'd2) begin
          m_busy <= 1;
          m_res <= golden(op, a, b);
          done_edge <= cyc + 1 + 5;
        end else if (op == 4'd3 || op == 4'd4) begin
          m_busy <= 1;
          m_res <= golden(op, a, b);
          done_edge <= cyc + 1 + 10;
        end else if (op == 4'd7) m_hi <= a;
        else if (op == 4'd8) m_lo <= a;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_hi", hi, m_hi);
    chk("model_lo", lo, m_lo);
    chk("model_rdata", rdata, op == 4'd5 ? m_hi : m_lo);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int n);
    op = o;
    a = x;
    b = y;
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= n; k++) begin
      chk("busy_window", 32'(busy), 32'd1);
      a = $urandom;
      b = $urandom;
      op = 4'(k);
      tick();
    end
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #1 reset = 1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    #10 reset = 0;
    tick();
    run(4'd1, 32'hFFFFFFFF, 32'd2, 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    run(4'd3, 32'hFFFFFFF9, 32'd2, 10);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    run(4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);
    run(4'd4, 32'd7, 32'd0, 10);
    chk("divu_z_hi", hi, 32'd7);
    chk("divu_z_lo", lo, 32'hFFFFFFFF);
    run(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    run(4'd3, 32'd7, 32'hFFFFFFFE, 10);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'd1);
    run(4'd3, 32'hFFFFFFFB, 32'd0, 10);
    chk("div_z_hi", hi, 32'hFFFFFFFB);
    chk("div_z_lo", lo, 32'hFFFFFFFF);
    op = 4'd1;
    a = 32'd3;
    b = 32'd4;
    start = 1;
    flush = 1;
    tick();
    start = 0;
    flush = 0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", hi, 32'hFFFFFFFB);
    chk("flush_lo", lo, 32'hFFFFFFFF);
    run(4'd8, 32'h1234, 32'd0, 0);
    chk("mtlo_lo", lo, 32'h1234);
    op = 4'd6;
    #1 chk("mflo_rdata", rdata, 32'h1234);
    run(4'd7, 32'hABCD, 32'd0, 0);
    chk("mthi_hi", hi, 32'hABCD);
    op = 4'd5;
    #1 chk("mfhi_rdata", rdata, 32'hABCD);
    run(4'd0, 32'd5, 32'd5, 0);
    run(4'd15, 32'd5, 32'd5, 0);
    chk("noop_hi", hi, 32'hABCD);
    chk("noop_lo", lo, 32'h1234);
    op = 4'd4;
    a = 32'd100;
    b = 32'd7;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    reset = 1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    #2 reset = 0;
    repeat (12) tick();
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_hi", hi, 32'd0);
    chk("postrst_lo", lo, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
